// File: rtl/twiddle_hload_ctrl.sv
// Stage-0 twiddle ROM loader: buffers NENT high then NENT low half-words and
// replays each set as a gap-free write burst on the ROM7_w / horizontal_data_in port.
module twiddle_hload_ctrl #(
   parameter int DW   = 64,
   parameter int NENT = 4,
   parameter int PW   = 2
) (
   input  logic          CLK,
   input  logic          rst_n,
   input  logic          load_start,
   input  logic          abort,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic [1:0]    rom_w,
   output logic [DW-1:0] rom_data,
   output logic          rom_hold,
   output logic          done
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FILL_HI  = 3'd1,
      S_BURST_HI = 3'd2,
      S_FILL_LO  = 3'd3,
      S_BURST_LO = 3'd4,
      S_DONE     = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] rd_nxt_s;
   logic [DW-1:0] buf_q [NENT];
   logic [DW-1:0] buf_d [NENT];
   logic [1:0]    rom_w_q, rom_w_d;
   logic [DW-1:0] rom_data_q, rom_data_d;
   logic          rom_hold_q, rom_hold_d;
   logic          done_q, done_d;
   logic          hs_s, wr_last_s, rd_last_s, is_hi_s;

   assign in_ready  = (state_q == S_FILL_HI) || (state_q == S_FILL_LO);
   assign hs_s      = in_valid & in_ready;
   assign wr_last_s = (wr_ptr_q == PW'(NENT - 1));
   assign rd_last_s = (rd_ptr_q == PW'(NENT - 1));
   assign rd_nxt_s  = rd_ptr_q + PW'(1);
   assign is_hi_s   = (state_q == S_FILL_HI) || (state_q == S_BURST_HI);

   assign rom_w    = rom_w_q;
   assign rom_data = rom_data_q;
   assign rom_hold = rom_hold_q;
   assign done     = done_q;

   // Next-state logic; rom_w/rom_data are computed one cycle ahead so the
   // registered burst starts the cycle after the final handshake of a half.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      buf_d      = buf_q;
      rom_w_d    = 2'd0;
      rom_data_d = {DW{1'b0}};
      rom_hold_d = rom_hold_q;
      done_d     = 1'b0;
      if (abort) begin
         state_d    = S_IDLE;
         wr_ptr_d   = {PW{1'b0}};
         rd_ptr_d   = {PW{1'b0}};
         rom_hold_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (load_start) begin
                  state_d    = S_FILL_HI;
                  wr_ptr_d   = {PW{1'b0}};
                  rom_hold_d = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_FILL_HI, S_FILL_LO: begin
               if (hs_s) begin
                  buf_d[wr_ptr_q] = in_data;
                  wr_ptr_d        = wr_ptr_q + PW'(1);
                  if (wr_last_s) begin
                     state_d    = is_hi_s ? S_BURST_HI : S_BURST_LO;
                     rd_ptr_d   = {PW{1'b0}};
                     rom_w_d    = is_hi_s ? 2'd1 : 2'd2;
                     rom_data_d = buf_q[0];
                  end else begin
                     state_d = state_q;
                  end
               end else begin
                  state_d = state_q;
               end
            end
            S_BURST_HI, S_BURST_LO: begin
               // rd_ptr tracks the entry currently on the ROM port
               if (rd_last_s) begin
                  rd_ptr_d = {PW{1'b0}};
                  state_d  = is_hi_s ? S_FILL_LO : S_DONE;
                  done_d   = !is_hi_s;
               end else begin
                  rd_ptr_d   = rd_nxt_s;
                  rom_w_d    = is_hi_s ? 2'd1 : 2'd2;
                  rom_data_d = buf_q[rd_nxt_s];
               end
            end
            S_DONE: begin
               state_d    = S_IDLE;
               rom_hold_d = 1'b0;
            end
            default: begin
               state_d    = S_IDLE;
               rom_hold_d = 1'b0;
            end
         endcase
      end
   end

   // State, pointer, buffer and output registers.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= {PW{1'b0}};
         rd_ptr_q   <= {PW{1'b0}};
         rom_w_q    <= 2'd0;
         rom_data_q <= {DW{1'b0}};
         rom_hold_q <= 1'b0;
         done_q     <= 1'b0;
         for (int i = 0; i < NENT; i++) begin
            buf_q[i] <= {DW{1'b0}};
         end
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         rom_w_q    <= rom_w_d;
         rom_data_q <= rom_data_d;
         rom_hold_q <= rom_hold_d;
         done_q     <= done_d;
         buf_q      <= buf_d;
      end
   end

endmodule

// File: tb/tb_twiddle_hload_ctrl.sv
// Directed bench for twiddle_hload_ctrl: scoreboard of expected ROM writes plus
// a model of the ROM entry counter to confirm the final ROM contents.
module tb_twiddle_hload_ctrl;

   logic        CLK = 1'b0;
   logic        rst_n, load_start, abort, in_valid;
   logic [63:0] in_data;
   logic        in_ready, rom_hold, done;
   logic [1:0]  rom_w;
   logic [63:0] rom_data;

   twiddle_hload_ctrl #(.DW(64), .NENT(4), .PW(2)) dut (
      .CLK(CLK), .rst_n(rst_n), .load_start(load_start), .abort(abort),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .rom_w(rom_w), .rom_data(rom_data), .rom_hold(rom_hold), .done(done)
   );

   always #5 CLK = ~CLK;

   int          n_chk = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   int          done_cyc = 0;
   int          first_hi = 0;
   int          first_lo = 0;
   int          run_len = 0;
   int          rom_cnt = 0;
   bit          skip_run = 1'b0;
   logic [1:0]  prev_w = 2'd0;
   logic [65:0] sb [$];
   logic [63:0] hi_w [4];
   logic [63:0] lo_w [4];
   logic [63:0] rom_hi [4];
   logic [63:0] rom_lo [4];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   always @(posedge CLK) cyc <= cyc + 1;

   // Output monitor: scoreboard pop, ROM model, burst-length and done tracking.
   always @(negedge CLK) begin
      logic [65:0] exp_e;
      if (prev_w != 2'd0 && rom_w != prev_w) begin
         if (!skip_run) check("burst_len", 128'(run_len), 128'(4));
         run_len = 0;
      end
      if (rom_w != 2'd0) begin
         if (prev_w == 2'd0) begin
            if (rom_w == 2'd1) first_hi = cyc;
            else first_lo = cyc;
         end
         run_len++;
         exp_e = (sb.size() > 0) ? sb.pop_front() : {2'd3, 64'hFFFF_FFFF_FFFF_FFFF};
         check("burst_word", 128'({rom_w, rom_data}), 128'(exp_e));
         check("in_ready_in_burst", 128'(in_ready), 128'(0));
         if (rom_cnt < 4) begin
            if (rom_w == 2'd1) rom_hi[rom_cnt] = rom_data;
            else rom_lo[rom_cnt] = rom_data;
         end
         rom_cnt++;
      end else begin
         rom_cnt = 0;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         check("hold_at_done", 128'(rom_hold), 128'(1));
      end
      prev_w = rom_w;
   end

   task automatic set_words(input logic [63:0] hb, input logic [63:0] lb);
      for (int k = 0; k < 4; k++) begin
         hi_w[k] = hb + 64'(k);
         lo_w[k] = lb + 64'(k);
      end
   endtask

   task automatic send_word(input logic [63:0] w, input logic [1:0] code,
                            input bit bubbly, input bit pulse_ls);
      int n;
      n = 0;
      if (bubbly) begin
         while ($urandom_range(1, 0) == 1 && n < 8) begin
            in_valid = 1'b0;
            step();
            n++;
         end
      end
      in_valid = 1'b1;
      in_data  = w;
      sb.push_back({code, w});
      n = 0;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      if (!in_ready) check("handshake_timeout", 128'(n), 128'(0));
      load_start = pulse_ls;
      step();
      load_start = 1'b0;
   endtask

   task automatic full_load(input bit bubbly, input bit ls_extra);
      int c0, dc0, n;
      c0  = cyc;
      dc0 = done_cnt;
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      check("hold_after_start", 128'(rom_hold), 128'(1));
      for (int k = 0; k < 4; k++) send_word(hi_w[k], 2'd1, bubbly, 1'b0);
      for (int k = 0; k < 4; k++) send_word(lo_w[k], 2'd2, bubbly, ls_extra && k == 1);
      in_valid = 1'b0;
      if (ls_extra) begin
         load_start = 1'b1;
         step();
         load_start = 1'b0;
      end
      n = 0;
      while (done_cnt == dc0 && n < 200) begin
         step();
         n++;
      end
      repeat (4) step();
      check("done_pulses", 128'(done_cnt - dc0), 128'(1));
      if (!bubbly) begin
         check("first_hi_lat", 128'(first_hi - c0), 128'(5));
         check("first_lo_lat", 128'(first_lo - c0), 128'(13));
         check("total_cycles", 128'(done_cyc - c0 + 1), 128'(18));
      end
      check("sb_drained", 128'(sb.size()), 128'(0));
      check("hold_released", 128'(rom_hold), 128'(0));
      check("idle_not_ready", 128'(in_ready), 128'(0));
      for (int k = 0; k < 4; k++)
         check("rom_entry", {rom_hi[k], rom_lo[k]}, {hi_w[k], lo_w[k]});
   endtask

   initial begin
      int dc0;
      rst_n = 1'b0; load_start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 64'd0;
      repeat (2) step();
      check("rst_rom_w", 128'(rom_w), 128'(0));
      check("rst_rom_data", 128'(rom_data), 128'(0));
      check("rst_hold", 128'(rom_hold), 128'(0));
      check("rst_done", 128'(done), 128'(0));
      check("rst_in_ready", 128'(in_ready), 128'(0));
      rst_n = 1'b1;
      step();

      // Continuous load, A0..A3 then B0..B3.
      set_words(64'hA0, 64'hB0);
      full_load(1'b0, 1'b0);

      // Bubbly input.
      set_words(64'h1234_5678_0000_0010, 64'h8765_4321_0000_0020);
      full_load(1'b1, 1'b0);

      // Abort after two high-half writes.
      set_words(64'hC0, 64'hD0);
      dc0 = done_cnt;
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      for (int k = 0; k < 4; k++) send_word(hi_w[k], 2'd1, 1'b0, 1'b0);
      in_valid = 1'b0;
      step();
      skip_run = 1'b1;
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_rom_w", 128'(rom_w), 128'(0));
      check("abort_hold", 128'(rom_hold), 128'(0));
      check("abort_sb_left", 128'(sb.size()), 128'(2));
      repeat (4) step();
      check("abort_no_done", 128'(done_cnt - dc0), 128'(0));
      check("abort_idle", 128'(in_ready), 128'(0));
      sb.delete();
      skip_run = 1'b0;
      set_words(64'hE0, 64'hF0);
      full_load(1'b0, 1'b0);

      // load_start pulsed during FILL_LO and BURST_LO.
      set_words(64'h5A00, 64'h6B00);
      full_load(1'b0, 1'b1);

      // Async reset during BURST_LO.
      set_words(64'h70, 64'h80);
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      for (int k = 0; k < 4; k++) send_word(hi_w[k], 2'd1, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) send_word(lo_w[k], 2'd2, 1'b0, 1'b0);
      in_valid = 1'b0;
      step();
      skip_run = 1'b1;
      check("pre_rst_lo_burst", 128'(rom_w), 128'(2));
      rst_n = 1'b0;
      #1;
      check("arst_rom_w", 128'(rom_w), 128'(0));
      check("arst_rom_data", 128'(rom_data), 128'(0));
      check("arst_hold", 128'(rom_hold), 128'(0));
      check("arst_done", 128'(done), 128'(0));
      check("arst_in_ready", 128'(in_ready), 128'(0));
      step();
      rst_n = 1'b1;
      in_valid = 1'b1;
      in_data = 64'h99;
      repeat (3) step();
      check("post_rst_ready", 128'(in_ready), 128'(0));
      check("post_rst_rom_w", 128'(rom_w), 128'(0));
      sb.delete();
      skip_run = 1'b0;

      // Stray in_valid in IDLE, held through the load_start cycle.
      in_data = 64'hDEAD;
      in_valid = 1'b1;
      repeat (3) begin
         step();
         check("stray_no_ready", 128'(in_ready), 128'(0));
      end
      set_words(64'h300, 64'h400);
      full_load(1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
